// File: rtl/stream_mux.sv
// ---------------------------------------------------------------------------
// stream_mux : N-input registered stream multiplexer, select or round-robin.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_mux #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int MODE      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATA_SIZE-1:0]        out_data,
  output logic [SEL_W-1:0]            out_src,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam logic [0:0]       S_EMPTY = 1'b0;
  localparam logic [0:0]       S_FULL  = 1'b1;
  localparam logic [SEL_W-1:0] C_LAST  = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   C_NUM   = (SEL_W + 1)'(NUM_IN);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [DATA_SIZE-1:0] r_data;
  logic [SEL_W-1:0]     r_src;
  logic [SEL_W-1:0]     w_grant;
  logic                 w_grant_vld;
  logic                 w_can_load;
  logic                 w_xfer;
  logic [DATA_SIZE-1:0] w_gdata;

  generate
    if (MODE == 0) begin : g_sel
      always_comb begin
        w_grant     = sel;
        w_grant_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) w_grant_vld = 1'b1;
        end
      end
    end else begin : g_rr
      logic [SEL_W-1:0]    r_ptr;
      logic [2*NUM_IN-1:0] w_rot;
      logic [SEL_W-1:0]    w_off;
      logic [SEL_W:0]      w_sum;
      logic                w_unused_sel;

      assign w_unused_sel = ^sel;
      // Rotate the valid vector so bit 0 is the channel at ptr; lowest set bit wins.
      assign w_rot = {in_valid, in_valid} >> r_ptr;

      always_comb begin
        w_off = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
          if (w_rot[k]) w_off = SEL_W'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= C_NUM) w_sum = w_sum - C_NUM;
        w_grant     = w_sum[SEL_W-1:0];
        w_grant_vld = |in_valid;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
        end
      end
    end
  endgenerate

  // Reset gates readiness so no producer sees a handshake while rst_n is low.
  assign w_can_load = rst_n && ((r_state == S_EMPTY) || out_ready);
  assign w_xfer     = w_grant_vld && w_can_load;

  always_comb begin
    w_gdata  = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_gdata     = in_data[i*DATA_SIZE +: DATA_SIZE];
        in_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)                               w_state_nxt = S_FULL;
    else if (r_state == S_FULL && out_ready) w_state_nxt = S_EMPTY;
  end

  always_comb begin
    out_valid = (r_state == S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= '0;
    end else if (w_xfer) begin
      r_data <= w_gdata;
      r_src  <= w_grant;
    end
  end

  assign out_data = r_data;
  assign out_src  = r_src;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_stream_mux : checks select, round-robin and invalid-select variants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_mux;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic [31:0] data;
    logic [1:0]  src;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] dat  [3];
  logic [3:0]   vld  [3];
  logic [1:0]   sl   [3];
  logic         ordy [3];

  logic [3:0]  rdy0, rdy2;
  logic [2:0]  rdy1;
  logic [31:0] od0, od1, od2;
  logic [1:0]  os0, os1, os2;
  logic        ov0, ov1, ov2;

  // reference model state
  logic        m_full [3];
  logic [31:0] m_data [3];
  int          m_src  [3];
  int          m_ptr  [3];

  int total = 0;
  int bad   = 0;
  vec_t tbl [4];

  always #5 clk = ~clk;

  stream_mux #(.DATA_SIZE(32), .NUM_IN(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy0),
    .sel(sl[0]), .out_data(od0), .out_src(os0), .out_valid(ov0), .out_ready(ordy[0]));

  stream_mux #(.DATA_SIZE(32), .NUM_IN(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1][95:0]), .in_valid(vld[1][2:0]), .in_ready(rdy1),
    .sel(sl[1]), .out_data(od1), .out_src(os1), .out_valid(ov1), .out_ready(ordy[1]));

  stream_mux #(.DATA_SIZE(32), .NUM_IN(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[2]), .in_valid(vld[2]), .in_ready(rdy2),
    .sel(sl[2]), .out_data(od2), .out_src(os2), .out_valid(ov2), .out_ready(ordy[2]));

  function automatic int nof(int d);
    return (d == 1) ? 3 : 4;
  endfunction

  // Grant from the rules: explicit select, or first valid scanning up from ptr.
  function automatic int ref_grant(int d);
    int n = nof(d);
    if (d != 2) begin
      if (int'(sl[d]) < n && vld[d][sl[d]]) return int'(sl[d]);
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      if (vld[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(int d, logic [3:0] ardy, logic av, logic [31:0] ad, logic [1:0] as);
    int g = ref_grant(d);
    logic [3:0] erdy = '0;
    if (g >= 0 && rst_n && (!m_full[d] || ordy[d])) erdy[g] = 1'b1;
    cmp($sformatf("dut%0d.in_ready", d), 32'(ardy), 32'(erdy));
    cmp($sformatf("dut%0d.out_valid", d), 32'(av), 32'(m_full[d]));
    cmp($sformatf("dut%0d.out_data", d), ad, m_data[d]);
    cmp($sformatf("dut%0d.out_src", d), 32'(as), 32'(m_src[d]));
  endtask

  task automatic check_all();
    check_dut(0, rdy0, ov0, od0, os0);
    check_dut(1, {1'b0, rdy1}, ov1, od1, os1);
    check_dut(2, rdy2, ov2, od2, os2);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_full[d] = 1'b0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0;
    end
  endtask

  // Check the settled cycle, clock it, and advance the model.
  task automatic tick();
    int   g [3];
    logic x [3];
    logic dr[3];
    #1;
    check_all();
    for (int d = 0; d < 3; d++) begin
      g[d]  = ref_grant(d);
      x[d]  = rst_n && g[d] >= 0 && (!m_full[d] || ordy[d]);
      dr[d] = m_full[d] && ordy[d];
    end
    @(posedge clk);
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (x[d]) begin
          m_full[d] = 1'b1;
          m_data[d] = dat[d][g[d]*32 +: 32];
          m_src[d]  = g[d];
          m_ptr[d]  = (g[d] + 1) % nof(d);
        end else if (dr[d]) begin
          m_full[d] = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      dat[d] = '0; vld[d] = '0; sl[d] = '0; ordy[d] = 1'b0;
    end
    model_reset();
    tbl[0] = '{sel: 2'd0, rdy: 4'b0001, data: 32'hAAAA, src: 2'd0};
    tbl[1] = '{sel: 2'd1, rdy: 4'b0010, data: 32'hBBBB, src: 2'd1};
    tbl[2] = '{sel: 2'd2, rdy: 4'b0100, data: 32'hCCCC, src: 2'd2};
    tbl[3] = '{sel: 2'd3, rdy: 4'b1000, data: 32'hDDDD, src: 2'd3};

    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // explicit select, table-driven
    dat[0]  = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    vld[0]  = 4'hF;
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sl[0] = tbl[i].sel;
      #1;
      cmp($sformatf("sel%0d.in_ready", i), 32'(rdy0), 32'(tbl[i].rdy));
      tick();
      cmp($sformatf("sel%0d.out_data", i), od0, tbl[i].data);
      cmp($sformatf("sel%0d.out_src", i), 32'(os0), 32'(tbl[i].src));
      cmp($sformatf("sel%0d.out_valid", i), 32'(ov0), 32'd1);
    end

    // out-of-range select on the 3-input instance
    vld[1] = 4'h7; sl[1] = 2'd3; ordy[1] = 1'b1;
    repeat (3) begin
      tick();
      cmp("badsel.in_ready", 32'(rdy1), 32'd0);
      cmp("badsel.out_valid", 32'(ov1), 32'd0);
    end

    // backpressure with a select change during the stall
    sl[0] = 2'd0; dat[0][31:0] = 32'h1234;
    tick();
    cmp("bp.load", od0, 32'h1234);
    ordy[0] = 1'b0; sl[0] = 2'd1; dat[0][63:32] = 32'h5678;
    repeat (5) begin
      tick();
      cmp("bp.hold_data", od0, 32'h1234);
      cmp("bp.hold_rdy", 32'(rdy0), 32'd0);
      cmp("bp.hold_valid", 32'(ov0), 32'd1);
    end
    ordy[0] = 1'b1;
    #1;
    cmp("bp.release_rdy", 32'(rdy0), 32'b0010);
    tick();
    cmp("bp.reload_data", od0, 32'h5678);
    cmp("bp.reload_valid", 32'(ov0), 32'd1);

    // round-robin fairness
    dat[2]  = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
    vld[2]  = 4'hF;
    ordy[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp($sformatf("rr_all%0d.src", k), 32'(os2), 32'(k % 4));
    end
    vld[2] = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      cmp($sformatf("rr_13_%0d.src", k), 32'(os2), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // wrap: grant 2 leaves ptr at 3, then only channel 0
    vld[2] = 4'b0100;
    tick();
    cmp("wrap.g2", 32'(os2), 32'd2);
    vld[2] = 4'b0001;
    #1;
    cmp("wrap.rdy0", 32'(rdy2), 32'b0001);
    tick();
    cmp("wrap.src0", 32'(os2), 32'd0);
    vld[2] = 4'b0011;
    #1;
    cmp("wrap.ptr1", 32'(rdy2), 32'b0010);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        vld[d]  = 4'($urandom);
        sl[d]   = 2'($urandom);
        ordy[d] = ($urandom_range(3) != 0);
        for (int l = 0; l < 4; l++) dat[d][l*32 +: 32] = $urandom;
      end
      vld[1][3] = 1'b0;
      tick();
    end

    // asynchronous reset while holding a word
    sl[0] = 2'd3; vld[0] = 4'hF; ordy[0] = 1'b0;
    dat[0] = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    tick();
    cmp("rst.pre_valid", 32'(ov0), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rst.async_valid", 32'(ov0), 32'd0);
    cmp("rst.async_data", od0, 32'd0);
    cmp("rst.async_src", 32'(os0), 32'd0);
    cmp("rst.async_rdy", 32'(rdy0), 32'd0);
    ordy[0] = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    sl[0] = 2'd2;
    #1;
    cmp("rst.first_rdy", 32'(rdy0), 32'b0100);
    tick();
    cmp("rst.first_valid", 32'(ov0), 32'd1);
    cmp("rst.first_data", od0, 32'hDEAD_0002);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
